monta_carga_entradas: RTL and testbench
=======================================

Name: monta_carga_entradas

Overview:
Input conditioning stage placed directly upstream of the freight-elevator controller FSM.
- Synchronizes and debounces the raw floor pushbuttons, limit switches (fines de carrera) and overweight sensor.
- Latches floor calls until the car reaches the called floor.
- Presents the controller with clean, stable P1..P3, FC1..FC3 and SP levels. Flags an inconsistent limit-switch state.

Parameters:
DEB_CYCLES, 40000, consecutive clk cycles an input must hold a new value before it is accepted (10 ms at 4 MHz); legal range 2..65535.
CNT_W, 16, width of each debounce counter; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
clk  input  1  system clock, 4 MHz board oscillator.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
p1_in, p2_in, p3_in  input  1 each  raw floor pushbuttons, active-high, asynchronous to clk.
fc1_in, fc2_in, fc3_in  input  1 each  raw floor limit switches, active-high, asynchronous.
sp_in  input  1  raw overweight sensor, active-high, asynchronous.
P1, P2, P3  output  1 each  latched floor-call requests to the controller.
FC1, FC2, FC3  output  1 each  debounced limit switches.
SP  output  1  debounced overweight.
fault  output  1  set while more than one debounced limit switch is active.

Behaviour:
- Reset (reset=0, asynchronous):
  - All sync flops, debounced values, counters and call latches clear to 0.
  - Outputs P1..P3, FC1..FC3, SP and fault are 0.
  - Release is sampled on the next clk rising edge.
- Synchronizer: each of the 7 raw inputs passes through a 2-flop synchronizer (s1 -> s2). No logic sits between the flops.
- Debounce (per input, independent):
  - Each input holds a stable value db and a counter cnt[CNT_W-1:0].
  - If s2 == db: cnt <= 0.
  - Else if cnt == DEB_CYCLES-1: db <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch back to db before the count completes restarts the count from 0.
  - Latency: a raw level held constant changes db on the (2+DEB_CYCLES)-th clk edge after the raw edge is first sampled.
- FC1..FC3 = db of fc inputs; SP = db of sp_in. These are registered outputs with no added latency beyond the debounce.
- Button edge: press_i is a 1-cycle pulse when db(p_i) goes 0->1 (registered previous-db compare). A release generates nothing.
- Call latch req_i, drives P_i. Priority per cycle, highest first:
  1. Clear: if FC_i == 1, req_i <= 0 (the car is at that floor; the call is served).
  2. Abort: if SP == 1, all req <= 0 (overweight cancels every call).
  3. Set: if press_i and fault == 0, req_i <= 1.
  4. Otherwise hold.
  - A press on the floor the car already occupies is therefore ignored.
  - Simultaneous press and clear on the same floor: clear wins.
  - Multiple calls may be latched at once. They persist, so the controller serves them in turn after each arrival.
- fault = 1 when two or more of FC1..FC3 are 1 (registered, same cycle as the FC update). While fault=1:
  - New calls are blocked.
  - Existing calls are held, except for the normal clear rule.
  - FC outputs still pass through unchanged.
- Counter wrap cannot occur: cnt resets at DEB_CYCLES-1.
- Reset asserted mid-debounce or mid-call discards all pending state. There is no recovery of calls.

Test Plan:
(Bench uses DEB_CYCLES=4.)
1. Reset and latency: hold reset=0 for 3 cycles -> all outputs 0. Release reset, raise fc1_in and hold -> FC1=1 exactly 6 edges after the first sampling edge; fault=0.
2. Glitch rejection: pulse p2_in high for 3 cycles, then low -> P2 stays 0. Hold p2_in high for 8 cycles with FC1=1 -> P2=1 after 6 edges and stays 1 after p2_in releases.
3. Call clear: from test 2 state (P2=1), drop fc1_in and raise fc2_in -> P2 falls to 0 on the same edge FC2 becomes 1. A later press of p2_in while FC2=1 leaves P2=0.
4. Multiple calls: with FC1=1, press p2 then p3 -> P2=P3=1. Raise FC2 -> P2=0, P3=1. Raise FC3 (FC2 low) -> P3=0.
5. Overweight abort: with P3=1, raise sp_in for 8 cycles -> SP=1 and P3=0 on the same edge. Press p2 while SP=1 -> P2 stays 0. Drop sp_in -> SP=0 after 6 edges.
6. Fault: hold fc1_in and fc3_in high -> FC1=FC3=1 and fault=1. Press p2 -> P2 stays 0. Drop fc3_in -> fault=0 after debounce. Press p2 -> P2=1. Assert reset asynchronously mid-count -> every output 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/monta_carga_entradas_if.sv
// Signal bundle between the raw elevator inputs and the controller-facing clean levels.
// The master side drives the raw buttons/switches; the slave side is the conditioning stage.
interface monta_carga_entradas_if;
    logic p1_in;
    logic p2_in;
    logic p3_in;
    logic fc1_in;
    logic fc2_in;
    logic fc3_in;
    logic sp_in;
    logic P1;
    logic P2;
    logic P3;
    logic FC1;
    logic FC2;
    logic FC3;
    logic SP;
    logic fault;

    modport master (
        output p1_in, p2_in, p3_in, fc1_in, fc2_in, fc3_in, sp_in,
        input  P1, P2, P3, FC1, FC2, FC3, SP, fault
    );

    modport slave (
        input  p1_in, p2_in, p3_in, fc1_in, fc2_in, fc3_in, sp_in,
        output P1, P2, P3, FC1, FC2, FC3, SP, fault
    );
endinterface

// File: rtl/monta_carga_entradas.sv
// Input conditioning for the freight-elevator controller: synchronize, debounce,
// latch floor calls until served, and flag contradictory limit-switch states.
module monta_carga_entradas #(
    parameter int DEB_CYCLES = 40000,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    monta_carga_entradas_if.slave bus
);
    localparam int               N_IN     = 7;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Bit order: [2:0] buttons p1..p3, [5:3] limit switches fc1..fc3, [6] overweight.
    logic [N_IN-1:0]  raw;
    logic [N_IN-1:0]  s1_q;
    logic [N_IN-1:0]  s1_d;
    logic [N_IN-1:0]  s2_q;
    logic [N_IN-1:0]  s2_d;
    logic [N_IN-1:0]  db_q;
    logic [N_IN-1:0]  db_d;
    logic [CNT_W-1:0] cnt_q [N_IN];
    logic [CNT_W-1:0] cnt_d [N_IN];
    logic [2:0]       req_q;
    logic [2:0]       req_d;
    logic             fault_q;
    logic             fault_d;
    logic [2:0]       press;
    logic [2:0]       fc_d;
    logic             sp_d;

    assign raw = {bus.sp_in, bus.fc3_in, bus.fc2_in, bus.fc1_in,
                  bus.p3_in, bus.p2_in, bus.p1_in};

    always_comb begin
        s1_d = raw;
        s2_d = s1_q;
        db_d = db_q;
        for (int i = 0; i < N_IN; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    // Call and fault logic look at the debounced values being loaded this edge,
    // so a clear or abort lands on the same edge the FC/SP output changes.
    always_comb begin
        fc_d    = db_d[5:3];
        sp_d    = db_d[6];
        fault_d = (fc_d[0] & fc_d[1]) | (fc_d[0] & fc_d[2]) | (fc_d[1] & fc_d[2]);
        press   = db_d[2:0] & ~db_q[2:0];
        req_d   = req_q;
        for (int i = 0; i < 3; i++) begin
            if (fc_d[i]) begin
                req_d[i] = 1'b0;
            end else if (sp_d) begin
                req_d[i] = 1'b0;
            end else if (press[i] && !fault_d) begin
                req_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            db_q    <= '0;
            req_q   <= '0;
            fault_q <= 1'b0;
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            db_q    <= db_d;
            req_q   <= req_d;
            fault_q <= fault_d;
            for (int i = 0; i < N_IN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.P1    = req_q[0];
    assign bus.P2    = req_q[1];
    assign bus.P3    = req_q[2];
    assign bus.FC1   = db_q[3];
    assign bus.FC2   = db_q[4];
    assign bus.FC3   = db_q[5];
    assign bus.SP    = db_q[6];
    assign bus.fault = fault_q;
endmodule

// File: tb/tb_monta_carga_entradas.sv
// Scoreboard bench for monta_carga_entradas with DEB_CYCLES=4: stimulus queues
// hand-computed expectations tagged with the edge they apply to; a monitor checks them.
module tb_monta_carga_entradas;
    localparam int DEB = 4;

    localparam logic [7:0] M_P1    = 8'h01;
    localparam logic [7:0] M_P2    = 8'h02;
    localparam logic [7:0] M_P3    = 8'h04;
    localparam logic [7:0] M_FC1   = 8'h08;
    localparam logic [7:0] M_FC2   = 8'h10;
    localparam logic [7:0] M_FC3   = 8'h20;
    localparam logic [7:0] M_SP    = 8'h40;
    localparam logic [7:0] M_FAULT = 8'h80;

    localparam logic [6:0] R_NONE = 7'h00;
    localparam logic [6:0] R_P2   = 7'h02;
    localparam logic [6:0] R_P3   = 7'h04;
    localparam logic [6:0] R_FC1  = 7'h08;
    localparam logic [6:0] R_FC2  = 7'h10;
    localparam logic [6:0] R_FC3  = 7'h20;
    localparam logic [6:0] R_SP   = 7'h40;

    typedef struct packed {
        int           cycle;
        bit           isAsync;
        logic [127:0] name;
        logic [7:0]   mask;
        logic [7:0]   value;
    } expect_t;

    expect_t    expectQ[$];
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    int         edgeCount = 0;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] obs;

    monta_carga_entradas_if bus();

    monta_carga_entradas #(.DEB_CYCLES(DEB), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    assign obs = {bus.fault, bus.SP, bus.FC3, bus.FC2, bus.FC1, bus.P3, bus.P2, bus.P1};

    task automatic applyStimulus(input logic [6:0] raw);
        @(negedge clk);
        {bus.sp_in, bus.fc3_in, bus.fc2_in, bus.fc1_in, bus.p3_in, bus.p2_in, bus.p1_in} = raw;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input logic [127:0] name, input int offset,
                               input logic [7:0] mask, input logic [7:0] value);
        expect_t e;
        e.cycle   = edgeCount + offset;
        e.isAsync = 1'b0;
        e.name    = name;
        e.mask    = mask;
        e.value   = value;
        expectQ.push_back(e);
    endtask

    task automatic checkAsync(input logic [127:0] name, input logic [7:0] mask,
                              input logic [7:0] value);
        expect_t e;
        e.cycle   = edgeCount;
        e.isAsync = 1'b1;
        e.name    = name;
        e.mask    = mask;
        e.value   = value;
        expectQ.push_back(e);
    endtask

    // Hold a button for 8 edges, verify the outputs one edge after acceptance, then release and settle.
    task automatic pressButton(input logic [6:0] base, input logic [6:0] btn,
                               input logic [127:0] name, input logic [7:0] mask,
                               input logic [7:0] value);
        applyStimulus(base | btn);
        checkOutput(name, DEB + 3, mask, value);
        waitCycles(7);
        applyStimulus(base);
        waitCycles(8);
    endtask

    function automatic void compare(input expect_t e);
        checks++;
        if ((obs & e.mask) !== e.value) begin
            failures++;
            $display("[TB] FAIL %0s at edge %0d: got %b, expected %b (mask %b)",
                     e.name, edgeCount, obs & e.mask, e.value, e.mask);
        end
    endfunction

    // A wake-up with clk high can only come from the reset falling mid-phase.
    initial begin
        expect_t e;
        forever begin
            @(negedge clk or negedge reset);
            #1;
            if (clk === 1'b1) begin
                if (expectQ.size() > 0 && expectQ[0].isAsync) begin
                    e = expectQ.pop_front();
                    compare(e);
                end
            end else begin
                while (expectQ.size() > 0 && !expectQ[0].isAsync && expectQ[0].cycle <= edgeCount) begin
                    e = expectQ.pop_front();
                    if (e.cycle < edgeCount) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL %0s: scheduled for edge %0d, not checked by edge %0d",
                                 e.name, e.cycle, edgeCount);
                    end else begin
                        compare(e);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        expect_t e;
        {bus.sp_in, bus.fc3_in, bus.fc2_in, bus.fc1_in, bus.p3_in, bus.p2_in, bus.p1_in} = R_NONE;
        reset = 1'b0;

        waitCycles(3);
        checkOutput("reset_hold", 0, 8'hFF, 8'h00);
        @(negedge clk);
        reset = 1'b1;

        applyStimulus(R_FC1);
        checkOutput("fc1_before", DEB + 1, M_FC1 | M_FAULT, 8'h00);
        checkOutput("fc1_latency", DEB + 2, M_FC1 | M_FAULT, M_FC1);
        waitCycles(8);

        applyStimulus(R_FC1 | R_P2);
        waitCycles(2);
        applyStimulus(R_FC1);
        checkOutput("glitch_p2_a", 3, M_P2, 8'h00);
        checkOutput("glitch_p2_b", 5, M_P2, 8'h00);
        checkOutput("glitch_p2_c", 8, M_P2, 8'h00);
        waitCycles(8);

        applyStimulus(R_FC1 | R_P2);
        checkOutput("p2_before", DEB + 1, M_P2, 8'h00);
        checkOutput("p2_latched", DEB + 2, M_P2, M_P2);
        waitCycles(7);
        applyStimulus(R_FC1);
        checkOutput("p2_held", 8, M_P2, M_P2);
        waitCycles(8);

        applyStimulus(R_FC2);
        checkOutput("clear_before", DEB + 1, M_P2 | M_FC1 | M_FC2 | M_FAULT, M_P2 | M_FC1);
        checkOutput("clear_arrive", DEB + 2, M_P2 | M_FC1 | M_FC2 | M_FAULT, M_FC2);
        waitCycles(8);
        pressButton(R_FC2, R_P2, "press_at_floor", M_P2 | M_FC2, M_FC2);

        applyStimulus(R_NONE);
        waitCycles(8);
        applyStimulus(R_FC1);
        checkOutput("back_to_fc1", DEB + 2, M_FC1 | M_FC2, M_FC1);
        waitCycles(8);
        pressButton(R_FC1, R_P2, "call_p2", M_P2, M_P2);
        pressButton(R_FC1, R_P3, "call_p2_p3", M_P2 | M_P3, M_P2 | M_P3);
        applyStimulus(R_FC2);
        checkOutput("multi_before", DEB + 1, M_P2 | M_P3, M_P2 | M_P3);
        checkOutput("multi_fc2", DEB + 2, M_P2 | M_P3 | M_FC2 | M_FAULT, M_P3 | M_FC2);
        waitCycles(8);
        applyStimulus(R_FC3);
        checkOutput("multi_fc3", DEB + 2, M_P3 | M_FC2 | M_FC3 | M_FAULT, M_FC3);
        waitCycles(8);

        applyStimulus(R_FC1);
        waitCycles(8);
        pressButton(R_FC1, R_P3, "relatch_p3", M_P3, M_P3);
        applyStimulus(R_FC1 | R_SP);
        checkOutput("sp_before", DEB + 1, M_SP | M_P3, M_P3);
        checkOutput("sp_abort", DEB + 2, M_SP | M_P3, M_SP);
        waitCycles(8);
        pressButton(R_FC1 | R_SP, R_P2, "press_overweight", M_P2 | M_SP, M_SP);
        applyStimulus(R_FC1);
        checkOutput("sp_release_before", DEB + 1, M_SP, M_SP);
        checkOutput("sp_release", DEB + 2, M_SP | M_P2 | M_P3, 8'h00);
        waitCycles(8);

        applyStimulus(R_FC1 | R_FC3);
        checkOutput("fault_before", DEB + 1, M_FC3 | M_FAULT, 8'h00);
        checkOutput("fault_set", DEB + 2, M_FC1 | M_FC3 | M_FAULT, M_FC1 | M_FC3 | M_FAULT);
        waitCycles(8);
        pressButton(R_FC1 | R_FC3, R_P2, "press_fault", M_P2 | M_FAULT, M_FAULT);
        applyStimulus(R_FC1);
        checkOutput("fault_hold", DEB + 1, M_FAULT, M_FAULT);
        checkOutput("fault_clear", DEB + 2, M_FAULT | M_FC1 | M_FC3, M_FC1);
        waitCycles(8);
        pressButton(R_FC1, R_P2, "press_after_fault", M_P2, M_P2);

        applyStimulus(R_FC1 | R_SP);
        waitCycles(2);
        checkOutput("pre_reset", 0, 8'hFF, M_FC1 | M_P2);
        @(posedge clk);
        #2;
        checkAsync("async_reset", 8'hFF, 8'h00);
        reset = 1'b0;
        waitCycles(2);
        checkOutput("reset_held", 0, 8'hFF, 8'h00);
        waitCycles(1);
        reset = 1'b1;

        for (int i = 0; i < 20 && expectQ.size() > 0; i++) begin
            @(negedge clk);
        end
        while (expectQ.size() > 0) begin
            e = expectQ.pop_front();
            checks++;
            failures++;
            $display("[TB] FAIL %0s: expectation never checked (edge %0d)", e.name, e.cycle);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
